// File: rtl/sdp_rd_arbiter.sv
// Round-robin arbiter sharing one SDP RAM read port between NUM_REQ requesters, with an
// in-order tag FIFO routing read data back to its issuer. Define SDP_RD_ARB_ERR_EN for err.
module sdp_rd_arbiter #(
    parameter int unsigned W_DATA          = 16,
    parameter int unsigned W_ADDR          = 16,
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_addr_valid,
    output logic [NUM_REQ-1:0]          req_addr_ready,
    input  logic [NUM_REQ*W_ADDR-1:0]   req_addr_data,
    output logic [NUM_REQ-1:0]          rsp_data_valid,
    input  logic [NUM_REQ-1:0]          rsp_data_ready,
    output logic [W_DATA-1:0]           rsp_data_data,
    output logic                        mem_addr_valid,
    input  logic                        mem_addr_ready,
    output logic [W_ADDR-1:0]           mem_addr_data,
    input  logic                        mem_data_valid,
    output logic                        mem_data_ready,
    input  logic [W_DATA-1:0]           mem_data_data
`ifdef SDP_RD_ARB_ERR_EN
    ,
    output logic                        err
`endif
);

    localparam int unsigned W_ID  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned W_PTR = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned W_CNT = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [W_ID-1:0]  LAST_ID  = W_ID'(NUM_REQ - 1);
    localparam logic [W_PTR-1:0] LAST_PTR = W_PTR'(MAX_OUTSTANDING - 1);
    localparam logic [W_CNT-1:0] FULL_CNT = W_CNT'(MAX_OUTSTANDING);

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t       state_q, state_d;
    logic [W_ID-1:0]  lock_id_q, lock_id_d;
    logic [W_ID-1:0]  rr_ptr_q, rr_ptr_d;
    logic [W_PTR-1:0] head_q, head_d;
    logic [W_PTR-1:0] tail_q, tail_d;
    logic [W_CNT-1:0] count_q, count_d;
    logic [W_ID-1:0]  tag_mem_q [MAX_OUTSTANDING];

    logic             lock_hold_c;
    logic [W_ID-1:0]  grant_c;
    logic [W_ID-1:0]  rr_cand_c;
    logic             rr_found_c;
    logic [W_ID-1:0]  head_id_c;
    logic             fifo_full_c;
    logic             fifo_empty_c;
    logic             push_c;
    logic             pop_c;

`ifdef SDP_RD_ARB_ERR_EN
    logic             lock_drop_c;
    logic             orphan_c;

    // A requester abandoning its locked address releases the lock in the same cycle.
    assign lock_drop_c = (state_q == ARB_LOCKED) && !req_addr_valid[lock_id_q];
    assign lock_hold_c = (state_q == ARB_LOCKED) &&  req_addr_valid[lock_id_q];
    assign orphan_c    = !rst && mem_data_valid && fifo_empty_c;
`else
    assign lock_hold_c = (state_q == ARB_LOCKED);
`endif

    // Grant selection: locked id, else first valid requester starting at rr_ptr.
    always_comb begin
        grant_c    = rr_ptr_q;
        rr_cand_c  = rr_ptr_q;
        rr_found_c = 1'b0;
        if (lock_hold_c) begin
            grant_c = lock_id_q;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!rr_found_c && req_addr_valid[rr_cand_c]) begin
                    grant_c    = rr_cand_c;
                    rr_found_c = 1'b1;
                end
                rr_cand_c = (rr_cand_c == LAST_ID) ? '0 : rr_cand_c + W_ID'(1);
            end
        end
    end

    // Address mux from the granted requester.
    always_comb begin
        mem_addr_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c == W_ID'(i)) begin
                mem_addr_data = req_addr_data[i*W_ADDR +: W_ADDR];
            end
        end
    end

    assign fifo_full_c  = (count_q == FULL_CNT);
    assign fifo_empty_c = (count_q == '0);
    assign head_id_c    = tag_mem_q[head_q];

    // Full FIFO blocks issue without looking at the pop side, keeping rsp ready off this path.
    assign mem_addr_valid = !rst && req_addr_valid[grant_c] && !fifo_full_c;
    assign mem_data_ready = !rst && rsp_data_ready[head_id_c] && !fifo_empty_c;
    assign rsp_data_data  = mem_data_data;

    always_comb begin
        req_addr_ready            = '0;
        rsp_data_valid            = '0;
        req_addr_ready[grant_c]   = !rst && mem_addr_ready && !fifo_full_c;
        rsp_data_valid[head_id_c] = !rst && mem_data_valid && !fifo_empty_c;
    end

    assign push_c = mem_addr_valid && mem_addr_ready;
    assign pop_c  = mem_data_valid && mem_data_ready;

    // Next-state: lock tracking, round-robin pointer and tag FIFO bookkeeping.
    always_comb begin
        state_d   = ARB_FREE;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (mem_addr_valid && !mem_addr_ready) begin
            state_d   = ARB_LOCKED;
            lock_id_d = grant_c;
        end

        if (push_c) begin
            rr_ptr_d = (grant_c == LAST_ID) ? '0 : grant_c + W_ID'(1);
            tail_d   = (tail_q == LAST_PTR) ? '0 : tail_q + W_PTR'(1);
        end

        if (pop_c) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + W_PTR'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + W_CNT'(1);
            2'b01:   count_d = count_q - W_CNT'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_FREE;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Tag storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_c) begin
            tag_mem_q[tail_q] <= grant_c;
        end
    end

`ifdef SDP_RD_ARB_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (orphan_c || lock_drop_c) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdp_rd_arbiter.sv
// Self-checking bench for sdp_rd_arbiter: 2 requesters, 1-cycle RAM model with
// mem[a] = a ^ 16'hA5A5, scoreboard of issued reads checked against routed responses.
module tb_sdp_rd_arbiter;

    localparam int unsigned W_DATA  = 16;
    localparam int unsigned W_ADDR  = 16;
    localparam int unsigned NUM_REQ = 2;
    localparam logic [15:0] XOR_KEY = 16'hA5A5;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] data;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_addr_valid;
    logic [NUM_REQ-1:0]        req_addr_ready;
    logic [NUM_REQ*W_ADDR-1:0] req_addr_data;
    logic [NUM_REQ-1:0]        rsp_data_valid;
    logic [NUM_REQ-1:0]        rsp_data_ready;
    logic [W_DATA-1:0]         rsp_data_data;
    logic                      mem_addr_valid;
    logic                      mem_addr_ready;
    logic [W_ADDR-1:0]         mem_addr_data;
    logic                      mem_data_valid;
    logic                      mem_data_ready;
    logic [W_DATA-1:0]         mem_data_data;
`ifdef SDP_RD_ARB_ERR_EN
    logic                      err;
`endif

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] pend0[$];
    logic [15:0] pend1[$];
    exp_t        exp_q[$];
    int          grant_log[$];
    int          hs_cyc_log[$];
    logic [1:0]  hs_pending = 2'b00;
    logic [15:0] ram_q[$];
    logic        ram_v = 1'b0;
    logic [15:0] ram_d = '0;
    logic        orphan_force;
    logic [15:0] mon_addr;
    exp_t        mon_exp;

    sdp_rd_arbiter #(
        .W_DATA          (W_DATA),
        .W_ADDR          (W_ADDR),
        .NUM_REQ         (NUM_REQ),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_addr_valid (req_addr_valid),
        .req_addr_ready (req_addr_ready),
        .req_addr_data  (req_addr_data),
        .rsp_data_valid (rsp_data_valid),
        .rsp_data_ready (rsp_data_ready),
        .rsp_data_data  (rsp_data_data),
        .mem_addr_valid (mem_addr_valid),
        .mem_addr_ready (mem_addr_ready),
        .mem_addr_data  (mem_addr_data),
        .mem_data_valid (mem_data_valid),
        .mem_data_ready (mem_data_ready),
        .mem_data_data  (mem_data_data)
`ifdef SDP_RD_ARB_ERR_EN
        ,
        .err            (err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM read port model: 1-cycle latency, holds data while stalled.
    always @(posedge clk) begin
        if (rst) begin
            ram_q.delete();
        end else begin
            if (mem_data_valid && mem_data_ready && ram_q.size() != 0) void'(ram_q.pop_front());
            if (mem_addr_valid && mem_addr_ready) ram_q.push_back(mem_addr_data ^ XOR_KEY);
        end
        ram_v <= (ram_q.size() != 0);
        ram_d <= (ram_q.size() != 0) ? ram_q[0] : 16'h0000;
    end

    assign mem_data_valid = ram_v | orphan_force;
    assign mem_data_data  = orphan_force ? 16'hDEAD : ram_d;

    // Requester drivers: present queue heads, advance after an accepted handshake.
    initial begin
        req_addr_valid = '0;
        req_addr_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (hs_pending[0] && pend0.size() != 0) void'(pend0.pop_front());
            if (hs_pending[1] && pend1.size() != 0) void'(pend1.pop_front());
            req_addr_valid[0]     = (pend0.size() != 0);
            req_addr_valid[1]     = (pend1.size() != 0);
            req_addr_data[15:0]   = (pend0.size() != 0) ? pend0[0] : 16'h0000;
            req_addr_data[31:16]  = (pend1.size() != 0) ? pend1[0] : 16'h0000;
        end
    end

    // Monitor just before each rising edge: scoreboard push on issue, pop/compare on return.
    always begin
        @(negedge clk);
        #4;
        hs_pending = req_addr_valid & req_addr_ready;
        if (rst) begin
            exp_q.delete();
            hs_pending = 2'b00;
        end else begin
            n_assert++;
            if ((mem_addr_valid && mem_addr_ready) !== (hs_pending != 2'b00) || hs_pending == 2'b11) begin
                n_fail++;
                $display("FAIL issue_match: mem hs=%b req hs=%b, required mem hs equal to a single req hs",
                         mem_addr_valid && mem_addr_ready, hs_pending);
            end
            for (int i = 0; i < 2; i++) begin
                if (hs_pending[i]) begin
                    mon_addr = req_addr_data[i*16 +: 16];
                    n_assert++;
                    if (mem_addr_data !== mon_addr) begin
                        n_fail++;
                        $display("FAIL issue_addr req%0d: mem_addr_data=%h, required %h", i, mem_addr_data, mon_addr);
                    end
                    mon_exp.id   = 8'(i);
                    mon_exp.data = mon_addr ^ XOR_KEY;
                    exp_q.push_back(mon_exp);
                    grant_log.push_back(i);
                    hs_cyc_log.push_back(cyc);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (rsp_data_valid[i] && rsp_data_ready[i]) begin
                    n_assert++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rsp_unexpected req%0d: data=%h, required no response", i, rsp_data_data);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_exp.id != 8'(i) || rsp_data_data !== mon_exp.data) begin
                            n_fail++;
                            $display("FAIL rsp_route: got req%0d data=%h, required req%0d data=%h",
                                     i, rsp_data_data, mon_exp.id, mon_exp.data);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pend0.size() != 0 || pend1.size() != 0) && k < 60) begin
            tick();
            k++;
        end
        tick();
        n_assert++;
        if (exp_q.size() != 0 || pend0.size() != 0 || pend1.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: outstanding=%0d pending=%0d/%0d, required 0/0/0",
                     name, exp_q.size(), pend0.size(), pend1.size());
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        mem_addr_ready = 1'b1;
        rsp_data_ready = 2'b11;
        orphan_force   = 1'b0;
        pend0.push_back(16'h0005);
        pend1.push_back(16'h1005);
        repeat (3) tick();
        n_assert++;
        if ({req_addr_ready, mem_addr_valid, rsp_data_valid, mem_data_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_gating: rdy=%b mav=%b rspv=%b mdr=%b, required all 0",
                     req_addr_ready, mem_addr_valid, rsp_data_valid, mem_data_ready);
        end
        rst = 1'b0;
        #1;
        n_assert++;
        if (req_addr_ready !== 2'b01 || mem_addr_valid !== 1'b1 || mem_addr_data !== 16'h0005) begin
            n_fail++;
            $display("FAIL reset_first_grant: rdy=%b mav=%b addr=%h, required 01 1 0005",
                     req_addr_ready, mem_addr_valid, mem_addr_data);
        end
        drain("reset");
    endtask

    task automatic test_single();
        pend0.push_back(16'h0010);
        tick();
        for (int i = 0; i < 4 && !mem_addr_valid; i++) tick();
        n_assert++;
        if (mem_addr_valid !== 1'b1 || req_addr_ready !== 2'b01 || mem_addr_data !== 16'h0010) begin
            n_fail++;
            $display("FAIL single_issue: mav=%b rdy=%b addr=%h, required 1 01 0010",
                     mem_addr_valid, req_addr_ready, mem_addr_data);
        end
        tick();
        n_assert++;
        if (rsp_data_valid !== 2'b01 || rsp_data_data !== 16'hA5B5 || mem_data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_rsp: rspv=%b data=%h mdr=%b, required 01 a5b5 1",
                     rsp_data_valid, rsp_data_data, mem_data_ready);
        end
        drain("single");
    endtask

    task automatic test_alternate();
        grant_log.delete();
        hs_cyc_log.delete();
        for (int i = 0; i < 4; i++) begin
            pend0.push_back(16'h0100 + 16'(i));
            pend1.push_back(16'h1100 + 16'(i));
        end
        repeat (14) tick();
        n_assert++;
        if (grant_log.size() != 8) begin
            n_fail++;
            $display("FAIL alt_count: grants=%0d, required 8", grant_log.size());
        end
        // Last grant before this test went to req0, so the pointer starts at req1.
        for (int k = 0; k < grant_log.size() && k < 8; k++) begin
            n_assert++;
            if (grant_log[k] != ((k % 2 == 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL alt_order[%0d]: grant=%0d, required %0d", k, grant_log[k], (k % 2 == 0) ? 1 : 0);
            end
        end
        if (hs_cyc_log.size() == 8) begin
            n_assert++;
            if (hs_cyc_log[7] - hs_cyc_log[0] != 7) begin
                n_fail++;
                $display("FAIL alt_throughput: span=%0d cycles, required 7", hs_cyc_log[7] - hs_cyc_log[0]);
            end
        end
        drain("alternate");
    endtask

    task automatic test_lock();
        mem_addr_ready = 1'b0;
        pend0.push_back(16'h0200);
        tick();
        n_assert++;
        if (mem_addr_valid !== 1'b1 || mem_addr_data !== 16'h0200 || req_addr_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL lock_stall: mav=%b addr=%h rdy=%b, required 1 0200 00",
                     mem_addr_valid, mem_addr_data, req_addr_ready);
        end
        pend1.push_back(16'h1200);
        repeat (3) begin
            tick();
            n_assert++;
            if (mem_addr_data !== 16'h0200 || mem_addr_valid !== 1'b1 || req_addr_valid !== 2'b11) begin
                n_fail++;
                $display("FAIL lock_hold: addr=%h mav=%b reqv=%b, required 0200 1 11",
                         mem_addr_data, mem_addr_valid, req_addr_valid);
            end
        end
        mem_addr_ready = 1'b1;
        #1;
        n_assert++;
        if (req_addr_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_release: rdy=%b, required 01", req_addr_ready);
        end
        tick();
        n_assert++;
        if (req_addr_ready !== 2'b10 || mem_addr_data !== 16'h1200) begin
            n_fail++;
            $display("FAIL lock_next: rdy=%b addr=%h, required 10 1200", req_addr_ready, mem_addr_data);
        end
        drain("lock");
    endtask

    task automatic test_full();
        rsp_data_ready = 2'b10;
        pend0.push_back(16'h0300);
        pend0.push_back(16'h0301);
        pend0.push_back(16'h0302);
        pend1.push_back(16'h1300);
        repeat (3) tick();
        repeat (5) begin
            n_assert++;
            if ({req_addr_ready, mem_addr_valid, rsp_data_valid, mem_data_ready} !== 6'b00_0_01_0) begin
                n_fail++;
                $display("FAIL full_block: rdy=%b mav=%b rspv=%b mdr=%b, required 00 0 01 0",
                         req_addr_ready, mem_addr_valid, rsp_data_valid, mem_data_ready);
            end
            tick();
        end
        rsp_data_ready = 2'b11;
        drain("full");
    endtask

    task automatic test_reset_mid();
        int k;
        rsp_data_ready = 2'b00;
        pend0.push_back(16'h0400);
        pend1.push_back(16'h1400);
        k = 0;
        while (exp_q.size() != 2 && k < 10) begin
            tick();
            k++;
        end
        n_assert++;
        if (exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL rmid_outstanding: outstanding=%0d, required 2", exp_q.size());
        end
        pend0.delete();
        pend1.delete();
        rst = 1'b1;
        tick();
        n_assert++;
        if ({req_addr_ready, mem_addr_valid, rsp_data_valid, mem_data_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL rmid_gating: rdy=%b mav=%b rspv=%b mdr=%b, required all 0",
                     req_addr_ready, mem_addr_valid, rsp_data_valid, mem_data_ready);
        end
        rst            = 1'b0;
        rsp_data_ready = 2'b11;
        pend0.push_back(16'h0500);
        pend1.push_back(16'h1500);
        tick();
        n_assert++;
        if (req_addr_ready !== 2'b01 || mem_addr_data !== 16'h0500) begin
            n_fail++;
            $display("FAIL rmid_first: rdy=%b addr=%h, required 01 0500", req_addr_ready, mem_addr_data);
        end
        tick();
        n_assert++;
        if (req_addr_ready !== 2'b10 || mem_addr_data !== 16'h1500) begin
            n_fail++;
            $display("FAIL rmid_second: rdy=%b addr=%h, required 10 1500", req_addr_ready, mem_addr_data);
        end
        drain("reset_mid");
    endtask

    task automatic test_orphan();
`ifdef SDP_RD_ARB_ERR_EN
        n_assert++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clean: err=%b, required 0", err);
        end
`endif
        orphan_force = 1'b1;
        #1;
        repeat (2) begin
            n_assert++;
            if ({rsp_data_valid, mem_data_ready} !== 3'b000) begin
                n_fail++;
                $display("FAIL orphan_stall: rspv=%b mdr=%b, required 00 0", rsp_data_valid, mem_data_ready);
            end
            tick();
        end
        orphan_force = 1'b0;
`ifdef SDP_RD_ARB_ERR_EN
        repeat (3) tick();
        n_assert++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_assert++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_reset: err=%b, required 0", err);
        end
`endif
        drain("orphan");
    endtask

    initial begin
        rst            = 1'b1;
        mem_addr_ready = 1'b1;
        rsp_data_ready = 2'b11;
        orphan_force   = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_full();
        test_reset_mid();
        test_orphan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at 200000, required completion");
        $fatal(1, "timeout");
    end

endmodule
